// File: rtl/tact_press_decoder_if.sv
// Event bus between the tact switch decoder and its consumers: raw pin in,
// debounced level and single-cycle event pulses out.
interface tact_press_decoder_if;
  logic Tact1;
  logic BTN_PRESSED;
  logic PRESS;
  logic RELEASE;
  logic CLICK;
  logic LONG;
  logic REPEAT;

  modport master (
    output Tact1,
    input  BTN_PRESSED,
    input  PRESS,
    input  RELEASE,
    input  CLICK,
    input  LONG,
    input  REPEAT
  );

  modport slave (
    input  Tact1,
    output BTN_PRESSED,
    output PRESS,
    output RELEASE,
    output CLICK,
    output LONG,
    output REPEAT
  );
endinterface

// File: rtl/tact_press_decoder.sv
// Tact switch decoder: 2-flop sync, debounce, press/release/click/long events.
// Optional auto-repeat while held long is enabled by defining TACT_REPEAT_EN.
module tact_press_decoder #(
  parameter int W_DB          = 18,
  parameter int DB_CYCLES     = 240000,
  parameter int W_HOLD        = 25,
  parameter int LONG_CYCLES   = 24000000
`ifdef TACT_REPEAT_EN
  , parameter int REPEAT_CYCLES = 4800000
`endif
) (
  input logic                  CLK_24MHz,
  input logic                  RESET_n,
  tact_press_decoder_if.slave  bus
);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_HELD     = 2'd1;
  localparam logic [1:0] ST_LONG     = 2'd2;

  localparam logic [W_DB-1:0]   DB_MAX   = W_DB'(DB_CYCLES - 1);
  localparam logic [W_DB-1:0]   DB_ONE   = {{(W_DB-1){1'b0}}, 1'b1};
  localparam logic [W_HOLD-1:0] LONG_MAX = W_HOLD'(LONG_CYCLES - 1);
  localparam logic [W_HOLD-1:0] HOLD_ONE = {{(W_HOLD-1){1'b0}}, 1'b1};
  localparam logic [W_HOLD-1:0] HOLD_SAT = {W_HOLD{1'b1}};
`ifdef TACT_REPEAT_EN
  localparam logic [W_HOLD-1:0] REP_MAX  = W_HOLD'(REPEAT_CYCLES - 1);
`endif

  logic              s1_q, s1_d;
  logic              s2_q, s2_d;
  logic              level_q, level_d;
  logic [W_DB-1:0]   db_cnt_q, db_cnt_d;
  logic [W_HOLD-1:0] hold_q, hold_d;
  logic [1:0]        state_q, state_d;
  logic              btn_q, btn_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              click_q, click_d;
  logic              long_q, long_d;
  logic              acc_press_s;
  logic              acc_release_s;
`ifdef TACT_REPEAT_EN
  logic              repeat_q, repeat_d;
`endif

  // Synchroniser and debounce: level holds the accepted raw polarity (1 = released).
  always_comb begin
    s1_d          = bus.Tact1;
    s2_d          = s1_q;
    level_d       = level_q;
    db_cnt_d      = '0;
    acc_press_s   = 1'b0;
    acc_release_s = 1'b0;
    if (s2_q != level_q) begin
      if (db_cnt_q == DB_MAX) begin
        level_d       = s2_q;
        db_cnt_d      = '0;
        acc_press_s   = ~s2_q;
        acc_release_s = s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_ONE;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Press-state machine and event pulse generation; release beats a coincident long.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    btn_d     = ~level_d;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
`ifdef TACT_REPEAT_EN
    repeat_d  = 1'b0;
`endif
    case (state_q)
      ST_RELEASED: begin
        if (acc_press_s) begin
          state_d = ST_HELD;
          hold_d  = '0;
          press_d = 1'b1;
        end else begin
          hold_d  = '0;
        end
      end
      ST_HELD: begin
        if (acc_release_s) begin
          state_d   = ST_RELEASED;
          hold_d    = '0;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else if (hold_q == LONG_MAX) begin
          state_d = ST_LONG;
          hold_d  = '0;
          long_d  = 1'b1;
        end else begin
          hold_d  = hold_q + HOLD_ONE;
        end
      end
      ST_LONG: begin
        if (acc_release_s) begin
          state_d   = ST_RELEASED;
          hold_d    = '0;
          release_d = 1'b1;
        end else begin
`ifdef TACT_REPEAT_EN
          if (hold_q == REP_MAX) begin
            hold_d   = '0;
            repeat_d = 1'b1;
          end else begin
            hold_d   = hold_q + HOLD_ONE;
          end
`else
          if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + HOLD_ONE;
          end else begin
            hold_d = hold_q;
          end
`endif
        end
      end
      default: begin
        state_d = ST_RELEASED;
        hold_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK_24MHz) begin
    if (!RESET_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      level_q   <= 1'b1;
      db_cnt_q  <= '0;
      hold_q    <= '0;
      state_q   <= ST_RELEASED;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
`ifdef TACT_REPEAT_EN
      repeat_q  <= 1'b0;
`endif
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
`ifdef TACT_REPEAT_EN
      repeat_q  <= repeat_d;
`endif
    end
  end

  assign bus.BTN_PRESSED = btn_q;
  assign bus.PRESS       = press_q;
  assign bus.RELEASE     = release_q;
  assign bus.CLICK       = click_q;
  assign bus.LONG        = long_q;
`ifdef TACT_REPEAT_EN
  assign bus.REPEAT      = repeat_q;
`else
  assign bus.REPEAT      = 1'b0;
`endif

endmodule

// File: doc/tact_press_decoder.md
Name: tact_press_decoder

Overview:
- Input-side companion to the LED chaser.
- Reads raw active-low tact switch pin `Tact1` (pressed = 1'b0) and synchronises it to `CLK_24MHz`.
- Debounces the input and decodes it into clean single-cycle events: press, release, short click, long press.
- Downstream logic (LED sequencers, mode selectors) consumes these events instead of sampling the raw pin.

Parameters:
- `W_DB`, 18: debounce counter width.
- `DB_CYCLES`, 240000: consecutive stable cycles before a level change is accepted (10 ms at 24 MHz). Must be ≥1 and < 2^`W_DB`.
- `W_HOLD`, 25: hold counter width.
- `LONG_CYCLES`, 24000000: hold cycles before `LONG` fires (1 s). Must be ≥1 and < 2^`W_HOLD`.
- `REPEAT_CYCLES`, 4800000: auto-repeat period (200 ms). Used only with `TACT_REPEAT_EN`.

Ports:
- `CLK_24MHz`  in  1  sole clock; all flops on rising edge.
- `RESET_n`  in  1  synchronous active-low reset.
- `Tact1`  in  1  raw switch pin, asynchronous; 0 = pressed.
- `BTN_PRESSED`  out  1  debounced level; 1 = pressed.
- `PRESS`  out  1  one-cycle pulse on accepted press.
- `RELEASE`  out  1  one-cycle pulse on accepted release.
- `CLICK`  out  1  one-cycle pulse on release before `LONG` fired.
- `LONG`  out  1  one-cycle pulse when hold reaches `LONG_CYCLES`.
- `REPEAT`  out  1  auto-repeat pulse; constant 0 without `TACT_REPEAT_EN`.

Behaviour:
- Reset: synchronous, active-low, one clock `CLK_24MHz`.
  - Sync flops load 1'b1 (released).
  - Debounce and hold counters load 0.
  - State = ST_RELEASED.
  - All outputs 0.
  - `RESET_n` low mid-press aborts everything; no `RELEASE`/`CLICK` is emitted.
- Synchroniser: two flops, `Tact1` -> s1 -> s2. Only s2 is used downstream.
- Debounce:
  - Accepted level L is held internally.
  - While s2 != L, the debounce counter increments.
  - When s2 == L, the counter clears to 0.
  - When the counter reaches `DB_CYCLES`-1 with s2 != L still true, L toggles and the counter clears (same edge).
  - Glitches shorter than `DB_CYCLES` cycles are never visible.
- Latency: raw edge to `BTN_PRESSED`/`PRESS` change = `DB_CYCLES`+2 clock edges.
- FSM states: ST_RELEASED, ST_HELD, ST_LONG.
  - ST_RELEASED -> ST_HELD on accepted press.
    - `PRESS`=1 for that cycle; `BTN_PRESSED`=1 from that edge.
    - Hold counter loads 0.
  - ST_HELD:
    - Hold counter increments each cycle.
    - When it reaches `LONG_CYCLES`-1: `LONG`=1 for one cycle, -> ST_LONG, hold counter clears.
    - On accepted release: `RELEASE`=1 and `CLICK`=1 in the same cycle, -> ST_RELEASED.
  - ST_LONG:
    - On accepted release: `RELEASE`=1, `CLICK`=0, -> ST_RELEASED.
  - Simultaneous events: if release is accepted in the same cycle the hold count would fire `LONG`, release wins. `LONG`=0, `CLICK`=1.
- Counter arithmetic:
  - All counters are unsigned.
  - The hold counter in ST_LONG saturates at all-ones; no wrap.
- Exclusivity: at most one of `PRESS`/`RELEASE` is high per cycle. `PRESS` and `LONG` are never simultaneous.
- Outputs are registered; no combinational path from `Tact1`.

Optional Feature:
- Macro: `TACT_REPEAT_EN`.
- When defined, in ST_LONG the hold counter counts 0..`REPEAT_CYCLES`-1 and wraps.
  - `REPEAT`=1 for one cycle at each wrap.
  - First `REPEAT` comes `REPEAT_CYCLES` cycles after `LONG`.
  - Counting stops on release; no `REPEAT` on the release cycle.
- When undefined, `REPEAT` is tied to 0 and the repeat logic is absent.

Test Plan (`DB_CYCLES`=4, `LONG_CYCLES`=20, `REPEAT_CYCLES`=5):
- Reset with `Tact1`=0 held -> all outputs 0 during reset. Release `RESET_n` -> `PRESS` pulses exactly 6 cycles later, `BTN_PRESSED`=1.
- `Tact1` low for 3 cycles then high -> no `PRESS`, `BTN_PRESSED` stays 0.
- Press held 10 cycles after `PRESS`, then released -> `RELEASE`=`CLICK`=1 together 6 cycles after raw rise. `LONG` never fires.
- Press held 40 cycles -> `LONG` pulses once, 20 cycles after `PRESS`. On release, `RELEASE`=1, `CLICK`=0.
- With `TACT_REPEAT_EN`, hold 37 cycles past `PRESS` -> `LONG` at +20, `REPEAT` at +25, +30, +35.
- Assert `RESET_n`=0 while in ST_HELD -> outputs 0 next edge. After reset release with `Tact1`=1, no `RELEASE`/`CLICK` ever appears.
